// File: rtl/m68k_bus_bridge.sv
// Bridges the asynchronous 68000 bus (AS/UDS/LDS/R-W/DTACK/BERR) onto a synchronous internal slave bus.
// Latency: SYNC_STAGES+2 edges from raw AS low to ds driven, plus one edge to DTACK when ack is immediate.
// Backpressure: the internal slave stalls via ack; BERR is raised after TIMEOUT_CYCLES ACCESS cycles without ack.
//
// Ports:
//   clk, reset                      - system clock, synchronous active-high reset
//   cpu_addr/as_n/uds_n/lds_n/rw    - CPU address and asynchronous strobes
//   cpu_data_in/out/oe              - CPU data bus, write data in, read data out with drive enable
//   cpu_dtack_n, cpu_berr_n         - CPU cycle termination, active low
//   addr/data_write/ds/rw           - internal slave request (registered)
//   data_read, ack                  - internal slave response (ack may be combinational on ds)
module m68k_bus_bridge #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [22:0] cpu_addr,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    output logic        cpu_data_oe,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    output logic [23:0] addr,
    output logic [15:0] data_write,
    input  logic [15:0] data_read,
    output logic [1:0]  ds,
    output logic        rw,
    input  logic        ack
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DTACK,
        ST_BERR
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
    logic [SYNC_STAGES-1:0] uds_sync_q, uds_sync_d;
    logic [SYNC_STAGES-1:0] lds_sync_q, lds_sync_d;
    logic as_s, uds_s, lds_s;

    logic [7:0]  cnt_q, cnt_d;
    logic        dtack_n_q, dtack_n_d;
    logic        berr_n_q, berr_n_d;
    logic        data_oe_q, data_oe_d;
    logic [15:0] data_out_q, data_out_d;
    logic [1:0]  ds_q, ds_d;
    logic        rw_q, rw_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] data_write_q, data_write_d;

    // Shift registers: new sample enters bit 0, synchronised value leaves the top bit.
    always_comb begin
        as_sync_d  = {as_sync_q[SYNC_STAGES-2:0], cpu_as_n};
        uds_sync_d = {uds_sync_q[SYNC_STAGES-2:0], cpu_uds_n};
        lds_sync_d = {lds_sync_q[SYNC_STAGES-2:0], cpu_lds_n};
    end

    assign as_s  = as_sync_q[SYNC_STAGES-1];
    assign uds_s = uds_sync_q[SYNC_STAGES-1];
    assign lds_s = lds_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dtack_n_d    = dtack_n_q;
        berr_n_d     = berr_n_q;
        data_oe_d    = data_oe_q;
        data_out_d   = data_out_q;
        ds_d         = ds_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;

        case (state_q)
            ST_IDLE: begin
                if (!as_s) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end else if (!uds_s || !lds_s) begin
                    // Write cycles reach here late: data strobes trail AS.
                    state_d      = ST_ACCESS;
                    addr_d       = {cpu_addr, 1'b0};
                    rw_d         = cpu_rw;
                    data_write_d = cpu_data_in;
                    ds_d         = {~uds_s, ~lds_s};
                    cnt_d        = 8'd0;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                // ack wins over a timeout landing on the same edge.
                if (ack) begin
                    state_d   = ST_DTACK;
                    if (rw_q) data_out_d = data_read;
                    data_oe_d = rw_q;
                    dtack_n_d = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d  = ST_BERR;
                    ds_d     = 2'b00;
                    berr_n_d = 1'b0;
                end
            end
            ST_DTACK: begin
                // ds drops only here, giving the slave one clean end-of-transfer edge.
                if (as_s) begin
                    state_d   = ST_IDLE;
                    dtack_n_d = 1'b1;
                    data_oe_d = 1'b0;
                    ds_d      = 2'b00;
                    rw_d      = 1'b1;
                end
            end
            ST_BERR: begin
                if (as_s) begin
                    state_d  = ST_IDLE;
                    berr_n_d = 1'b1;
                    rw_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            as_sync_q    <= '1;
            uds_sync_q   <= '1;
            lds_sync_q   <= '1;
            cnt_q        <= 8'd0;
            dtack_n_q    <= 1'b1;
            berr_n_q     <= 1'b1;
            data_oe_q    <= 1'b0;
            data_out_q   <= 16'd0;
            ds_q         <= 2'b00;
            rw_q         <= 1'b1;
            addr_q       <= 24'd0;
            data_write_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            as_sync_q    <= as_sync_d;
            uds_sync_q   <= uds_sync_d;
            lds_sync_q   <= lds_sync_d;
            cnt_q        <= cnt_d;
            dtack_n_q    <= dtack_n_d;
            berr_n_q     <= berr_n_d;
            data_oe_q    <= data_oe_d;
            data_out_q   <= data_out_d;
            ds_q         <= ds_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
        end
    end

    assign cpu_dtack_n  = dtack_n_q;
    assign cpu_berr_n   = berr_n_q;
    assign cpu_data_oe  = data_oe_q;
    assign cpu_data_out = data_out_q;
    assign ds           = ds_q;
    assign rw           = rw_q;
    assign addr         = addr_q;
    assign data_write   = data_write_q;

endmodule
